// File: rtl/corr_pkg.sv
// -----------------------------------------------------------------------------
// corr_pkg
//
// Purpose:
//   Shared definitions for the correlation frame source:
//     - default sample width, maximum snapshot count and buffer address width
//     - output product width
//     - FSM state encoding used by corr_frame_gen
//
// Contents:
//   DATA_W_DEF   default signed sample width per channel
//   MAX_LEN_DEF  default maximum snapshots per frame
//   ADDR_W_DEF   default buffer address width, clog2(MAX_LEN_DEF)
//   OUT_W        width of the sign-extended product on o_data
//   corr_state_e frame FSM states
// -----------------------------------------------------------------------------
package corr_pkg;

    localparam int DATA_W_DEF  = 12;
    localparam int MAX_LEN_DEF = 64;
    localparam int ADDR_W_DEF  = 6;
    localparam int OUT_W       = 32;

    // IDLE  : waiting for a start pulse
    // FILL  : accepting sample pairs and storing their products
    // BURST : replaying the stored products as one gap-free burst
    // GUARD : one idle output cycle so the downstream accumulator clears
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2,
        ST_GUARD = 2'd3
    } corr_state_e;

endpackage : corr_pkg

// File: rtl/corr_prod_ram.sv
// -----------------------------------------------------------------------------
// corr_prod_ram
//
// Purpose:
//   Simple dual-port product buffer: one write port, one read port.
//   The read is registered, so data for i_rd_addr appears on o_rd_data one
//   cycle after i_rd_en is sampled high. o_rd_data holds its value while
//   i_rd_en is low.
//
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read strobe
//   i_rd_addr  read address
//   o_rd_data  registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module corr_prod_ram
    import corr_pkg::*;
#(
    parameter int DEPTH  = MAX_LEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WIDTH  = OUT_W
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // NOTE: the storage array has no reset so it maps onto block RAM; every
    // entry read during a burst was written earlier in the same frame.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : corr_prod_ram

// File: rtl/corr_frame_gen.sv
// -----------------------------------------------------------------------------
// corr_frame_gen
//
// Purpose:
//   Source side of the correlation accumulation stream. Collects one snapshot
//   of len sample pairs (a, b), stores the signed product a*b of each pair,
//   then replays the products as a single gap-free burst framed by
//   o_valid/o_last, followed by one guard cycle with o_valid low so the
//   downstream accumulator clears between frames.
//
//   Timing: if T is the cycle of the final input transfer, the first o_valid
//   is at T+2, o_valid stays high for exactly len cycles, and the next cycle
//   (GUARD) has o_valid=0 with o_busy still high.
//
// Optional feature (macro CORR_FRAME_CNT_EN):
//   Adds o_frame_cnt, a 16-bit wrapping count of emitted o_last cycles.
//   Without the macro the port and counter are absent.
//
// Ports:
//   i_clk        clock
//   i_resetn     asynchronous active-low reset
//   i_start      frame start pulse, honoured only in IDLE
//   i_len        snapshot count, legal 1..MAX_LEN, sampled on i_start
//   i_a, i_b     signed samples, channel A and channel B
//   i_in_valid   sample pair valid
//   o_in_ready   pair accepted when i_in_valid and o_in_ready are both high
//   o_data       sign-extended product a*b
//   o_valid      product valid
//   o_last       final product of the frame
//   o_busy       FSM is not in IDLE
//   o_frame_cnt  (CORR_FRAME_CNT_EN only) completed frame count
//   o_err        one-cycle pulse when i_start carries an illegal i_len
// -----------------------------------------------------------------------------
module corr_frame_gen
    import corr_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic                     i_start,
    input  logic [ADDR_W:0]          i_len,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic [OUT_W-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_last,
    output logic                     o_busy,
`ifdef CORR_FRAME_CNT_EN
    output logic [15:0]              o_frame_cnt,
`endif
    output logic                     o_err
);

    localparam int              PROD_W  = 2 * DATA_W;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    // Registered state
    corr_state_e     r_state;
    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic            r_valid;
    logic            r_last;
    logic            r_err;

    // Combinational nets
    logic signed [PROD_W-1:0] w_prod;
    logic [OUT_W-1:0]         w_prod_ext;
    logic [OUT_W-1:0]         w_rd_data;
    logic                     w_xfer;
    logic                     w_len_ok;
    logic                     w_rd_en;

    // ---------------------------------------------------------------------
    // Product path: full-precision signed multiply, then sign extension.
    // Both operands are signed, so the multiply is evaluated at PROD_W
    // bits with sign extension and -2048 * -2048 keeps its full value.
    // ---------------------------------------------------------------------
    assign w_prod     = i_a * i_b;
    assign w_prod_ext = OUT_W'(w_prod);

    // ---------------------------------------------------------------------
    // Handshake and status decode
    // ---------------------------------------------------------------------
    assign o_in_ready = (r_state == ST_FILL);
    assign o_busy     = (r_state != ST_IDLE);
    assign w_xfer     = i_in_valid && o_in_ready;
    assign w_len_ok   = (i_len != '0) && (i_len <= LEN_MAX);

    // Reads are issued while the burst still has unread entries; the
    // registered RAM output lines up with r_valid one cycle later.
    assign w_rd_en    = (r_state == ST_BURST) && (r_rd_ptr < r_len);

    // ---------------------------------------------------------------------
    // Product buffer
    // ---------------------------------------------------------------------
    corr_prod_ram #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W),
        .WIDTH  (OUT_W)
    ) u_prod_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_xfer),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (w_prod_ext),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    // ---------------------------------------------------------------------
    // Frame FSM with registered framing outputs
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge values of r_* regardless of order.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // Pulses default low; the states below raise them as needed.
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_len_ok) begin
                            r_len    <= i_len;
                            r_wr_ptr <= '0;
                            r_state  <= ST_FILL;
                        end else begin
                            r_err    <= 1'b1;
                        end
                    end
                end

                ST_FILL: begin
                    if (w_xfer) begin
                        r_wr_ptr <= r_wr_ptr + ONE;
                        if (r_wr_ptr == r_len - ONE) begin
                            r_rd_ptr <= '0;
                            r_state  <= ST_BURST;
                        end
                    end
                end

                ST_BURST: begin
                    if (w_rd_en) begin
                        r_rd_ptr <= r_rd_ptr + ONE;
                        r_valid  <= 1'b1;
                        r_last   <= (r_rd_ptr == r_len - ONE);
                    end
                    // Leave only once the last product is actually on the
                    // output, so GUARD is a cycle with o_valid low.
                    if (r_last) begin
                        r_state <= ST_GUARD;
                    end
                end

                ST_GUARD: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_err   = r_err;

    // The RAM read register is not reset; gating with r_valid keeps o_data
    // at zero during and after reset and between bursts.
    assign o_data  = r_valid ? w_rd_data : '0;

`ifdef CORR_FRAME_CNT_EN
    // ---------------------------------------------------------------------
    // Completed-frame counter: counts o_last cycles, wraps at 16 bits.
    // A frame aborted by reset never reaches o_last, so it is not counted.
    // ---------------------------------------------------------------------
    logic [15:0] r_frame_cnt;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_frame_cnt <= '0;
        end else if (r_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule : corr_frame_gen

// File: tb/tb_corr_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_corr_frame_gen
//
// Self-checking bench for corr_frame_gen. A behavioural model tracks, per
// clock cycle, which products must appear on the output, when the block is
// busy, ready or signalling an error, and compares the DUT every cycle.
// Directed scenarios add hand-computed literal expectations.
// Honours CORR_FRAME_CNT_EN for the optional frame counter.
// -----------------------------------------------------------------------------
module tb_corr_frame_gen;

    localparam int DATA_W  = 12;
    localparam int MAX_LEN = 64;
    localparam int ADDR_W  = 6;

    logic                     i_clk      = 1'b0;
    logic                     i_resetn   = 1'b0;
    logic                     i_start    = 1'b0;
    logic [ADDR_W:0]          i_len      = '0;
    logic signed [DATA_W-1:0] i_a        = '0;
    logic signed [DATA_W-1:0] i_b        = '0;
    logic                     i_in_valid = 1'b0;
    logic                     o_in_ready;
    logic [31:0]              o_data;
    logic                     o_valid;
    logic                     o_last;
    logic                     o_busy;
    logic                     o_err;
`ifdef CORR_FRAME_CNT_EN
    logic [15:0]              o_frame_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    corr_frame_gen #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (ADDR_W)
    ) dut (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_last      (o_last),
        .o_busy      (o_busy),
`ifdef CORR_FRAME_CNT_EN
        .o_frame_cnt (o_frame_cnt),
`endif
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Cycle c spans posedge c .. posedge c+1; sampled at its negedge.
    always @(posedge i_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a frame accepted at cycle s is busy from s+1; its
    // final transfer at T schedules product k at cycle T+2+k, and busy ends
    // after the guard cycle T+len+2.
    // ------------------------------------------------------------------
    int          busy_lo = 1;
    int          busy_hi = 0;
    int          err_cyc = -1;
    bit          filling = 1'b0;
    int          m_len   = 0;
    logic [31:0] m_q[$];
    logic [31:0] exp_data[int];
    bit          exp_last[int];
    logic [15:0] m_cnt   = '0;
    int          valid_total = 0;

    always @(negedge i_clk) begin
        bit eb;
        if (!i_resetn) begin
            busy_lo = 1;
            busy_hi = 0;
            err_cyc = -1;
            filling = 1'b0;
            m_q.delete();
            exp_data.delete();
            exp_last.delete();
            m_cnt   = '0;
            check("reset_data", o_data, 32'd0);
        end

        eb = (cyc >= busy_lo) && (cyc <= busy_hi);
        check("busy", 32'(o_busy), 32'(eb));
        check("in_ready", 32'(o_in_ready), 32'(filling));
        check("err", 32'(o_err), 32'(cyc == err_cyc));
        if (exp_data.exists(cyc)) begin
            check("valid", 32'(o_valid), 32'd1);
            check("data", o_data, exp_data[cyc]);
            check("last", 32'(o_last), 32'(exp_last[cyc]));
        end else begin
            check("valid", 32'(o_valid), 32'd0);
            check("last", 32'(o_last), 32'd0);
        end
`ifdef CORR_FRAME_CNT_EN
        check("frame_cnt", 32'(o_frame_cnt), 32'(m_cnt));
        if (exp_data.exists(cyc) && exp_last[cyc]) m_cnt = m_cnt + 16'd1;
`endif
        if (o_valid) valid_total++;
        if (exp_data.exists(cyc)) begin
            exp_data.delete(cyc);
            exp_last.delete(cyc);
        end

        if (i_resetn) begin
            // Transfers first: a start in this cycle only opens FILL next cycle.
            if (filling && i_in_valid) begin
                m_q.push_back(32'(int'(i_a) * int'(i_b)));
                if (m_q.size() == m_len) begin
                    for (int k = 0; k < m_len; k++) begin
                        exp_data[cyc + 2 + k] = m_q[k];
                        exp_last[cyc + 2 + k] = (k == m_len - 1);
                    end
                    busy_hi = cyc + m_len + 2;
                    filling = 1'b0;
                end
            end
            if (i_start && !eb) begin
                if (int'(i_len) >= 1 && int'(i_len) <= MAX_LEN) begin
                    busy_lo = cyc + 1;
                    busy_hi = 32'h3fff_ffff;
                    filling = 1'b1;
                    m_len   = int'(i_len);
                    m_q.delete();
                end else begin
                    err_cyc = cyc + 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at posedge + 1)
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] pa[MAX_LEN];
    logic signed [DATA_W-1:0] pb[MAX_LEN];
    logic [31:0]              cap_d[$];
    logic                     cap_l[$];
    int                       cap_first;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start(input int len);
        i_start = 1'b1;
        i_len   = (ADDR_W + 1)'(len);
        tick();
        i_start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
    task automatic feed(input int n, input int mode, output int t_last);
        int k      = 0;
        int budget = 0;
        bit ph     = 1'b1;
        bit xfer;
        t_last = -1;
        while (k < n && budget < 1000) begin
            i_a = pa[k];
            i_b = pb[k];
            case (mode)
                0:       i_in_valid = 1'b1;
                1:       i_in_valid = ph;
                default: i_in_valid = 1'($urandom % 2);
            endcase
            ph = !ph;
            @(negedge i_clk);
            xfer = i_in_valid && o_in_ready;
            if (xfer) t_last = cyc;
            tick();
            if (xfer) k++;
            budget++;
        end
        i_in_valid = 1'b0;
        if (k < n) check("feed_timeout", 32'(k), 32'(n));
    endtask

    // Returns at the negedge of the first non-valid cycle after the burst.
    task automatic capture(input int budget);
        cap_d.delete();
        cap_l.delete();
        cap_first = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_valid) begin
                if (cap_first < 0) cap_first = cyc;
                cap_d.push_back(o_data);
                cap_l.push_back(o_last);
            end else if (cap_first >= 0) begin
                break;
            end
        end
        if (cap_first < 0) check("capture_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge i_clk);
        while (o_busy && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        if (o_busy) check("idle_timeout", 32'(o_busy), 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int v0;

        // ---------------- reset state ----------------
        @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ready", 32'(o_in_ready), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_data", o_data, 32'd0);
        tick();
        tick();
        i_resetn = 1'b1;
        tick();
        tick();

        // ---------------- len=4 directed ----------------
        pa[0] = 12'sd1;  pb[0] = 12'sd2;
        pa[1] = 12'sd3;  pb[1] = -12'sd4;
        pa[2] = -12'sd5; pb[2] = 12'sd6;
        pa[3] = 12'sd7;  pb[3] = 12'sd8;
        pulse_start(4);
        feed(4, 0, t);
        capture(20);
        check("t1_count", 32'(cap_d.size()), 32'd4);
        check("t1_latency", 32'(cap_first - t), 32'd2);
        check("t1_d0", cap_d[0], 32'd2);
        check("t1_d1", cap_d[1], 32'hFFFF_FFF4);
        check("t1_d2", cap_d[2], 32'hFFFF_FFE2);
        check("t1_d3", cap_d[3], 32'd56);
        check("t1_last0", 32'(cap_l[0]), 32'd0);
        check("t1_last3", 32'(cap_l[3]), 32'd1);
        check("t1_guard_busy", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        check("t1_busy_falls", 32'(o_busy), 32'd0);
        tick();
`ifdef CORR_FRAME_CNT_EN
        check("t1_cnt", 32'(o_frame_cnt), 32'd1);
`endif

        // ---------------- len=1 extreme product ----------------
        pa[0] = -12'sd2048;
        pb[0] = -12'sd2048;
        pulse_start(1);
        feed(1, 0, t);
        capture(20);
        check("t2_count", 32'(cap_d.size()), 32'd1);
        check("t2_data", cap_d[0], 32'd4194304);
        check("t2_last", 32'(cap_l[0]), 32'd1);
        wait_idle();
`ifdef CORR_FRAME_CNT_EN
        check("t2_cnt", 32'(o_frame_cnt), 32'd2);
`endif

        // ---------------- illegal lengths ----------------
        pulse_start(0);
        @(negedge i_clk);
        check("t3_err_len0", 32'(o_err), 32'd1);
        check("t3_busy_len0", 32'(o_busy), 32'd0);
        tick();
        @(negedge i_clk);
        check("t3_err_clear", 32'(o_err), 32'd0);
        tick();
        pulse_start(65);
        @(negedge i_clk);
        check("t3_err_len65", 32'(o_err), 32'd1);
        check("t3_busy_len65", 32'(o_busy), 32'd0);
        tick();
        pulse_start(127);
        @(negedge i_clk);
        check("t3_err_len127", 32'(o_err), 32'd1);
        tick();
        tick();

        // ---------------- len=64, sparse input, start during burst ----------------
        for (int k = 0; k < MAX_LEN; k++) begin
            pa[k] = DATA_W'($urandom);
            pb[k] = DATA_W'($urandom);
        end
        v0 = valid_total;
        pulse_start(64);
        feed(64, 1, t);
        tick();
        tick();
        tick();
        pulse_start(3);
        wait_idle();
        check("t4_valid_cycles", 32'(valid_total - v0), 32'd64);
        check("t4_no_restart", 32'(o_busy), 32'd0);
`ifdef CORR_FRAME_CNT_EN
        check("t4_cnt", 32'(o_frame_cnt), 32'd3);
`endif

        // ---------------- reset mid-burst ----------------
        for (int k = 0; k < 8; k++) begin
            pa[k] = DATA_W'($urandom);
            pb[k] = DATA_W'($urandom);
        end
        pulse_start(8);
        feed(8, 0, t);
        tick();
        tick();
        i_resetn = 1'b0;
        #1;
        check("t5_rst_valid", 32'(o_valid), 32'd0);
        check("t5_rst_data", o_data, 32'd0);
        check("t5_rst_busy", 32'(o_busy), 32'd0);
        tick();
        tick();
        i_resetn = 1'b1;
        tick();
        tick();
        @(negedge i_clk);
        check("t5_post_valid", 32'(o_valid), 32'd0);
        check("t5_post_busy", 32'(o_busy), 32'd0);
        tick();
        pa[0] = 12'sd5;   pb[0] = -12'sd7;
        pa[1] = 12'sd100; pb[1] = 12'sd3;
        pulse_start(2);
        feed(2, 0, t);
        capture(20);
        check("t5_count", 32'(cap_d.size()), 32'd2);
        check("t5_d0", cap_d[0], 32'hFFFF_FFDD);
        check("t5_d1", cap_d[1], 32'd300);
        check("t5_last1", 32'(cap_l[1]), 32'd1);
        wait_idle();

        // ---------------- randomized frames ----------------
        for (int f = 0; f < 25; f++) begin
            int len;
            if ($urandom % 4 == 0) begin
                pulse_start(($urandom % 2 == 0) ? 0 : int'($urandom_range(65, 127)));
                tick();
            end
            len = int'($urandom_range(1, MAX_LEN));
            for (int k = 0; k < len; k++) begin
                pa[k] = DATA_W'($urandom);
                pb[k] = DATA_W'($urandom);
            end
            pulse_start(len);
            feed(len, 2, t);
            if ($urandom % 2 == 0) pulse_start(int'($urandom_range(1, MAX_LEN)));
            wait_idle();
            repeat ($urandom % 3) tick();
        end

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_corr_frame_gen

// File: doc/corr_frame_gen.md
Name: corr_frame_gen

Overview:
- Source side of the correlation accumulation stream.
- Collects one snapshot of N sample pairs (a, b) from two antenna channels and forms the product a*b per pair. Products are buffered, then replayed as one gap-free burst with valid/last framing.
- The downstream correlation accumulator clears whenever valid is low. This block therefore guarantees valid stays high for the whole frame, and is followed by at least one idle cycle.

Parameters:
- DATA_W, 12, signed sample width per channel; the product (2*DATA_W bits) must fit within 25 bits.
- MAX_LEN, 64, maximum snapshots per frame.
- ADDR_W, 6, buffer address width; clog2(MAX_LEN).

Ports:
- i_clk  in  1  clock
- i_resetn  in  1  asynchronous active-low reset
- i_start  in  1  frame start pulse; honoured only in IDLE
- i_len  in  ADDR_W+1  snapshot count for the frame, legal 1..MAX_LEN, sampled on i_start
- i_a  in  DATA_W  signed sample, channel A
- i_b  in  DATA_W  signed sample, channel B
- i_in_valid  in  1  sample pair valid
- o_in_ready  out  1  block accepts a pair; transfer occurs when i_in_valid and o_in_ready are both high
- o_data  out  32  sign-extended product a*b
- o_valid  out  1  product valid
- o_last  out  1  final product of the frame
- o_busy  out  1  state is not IDLE
- o_err  out  1  one-cycle pulse on an illegal i_len

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0, the FSM goes to IDLE, and write/read pointers and the length register clear. Buffer contents are not reset.
- Reset asserted mid-frame aborts the frame; no partial burst is emitted after release.
- FSM states: IDLE, FILL, BURST, GUARD.
- IDLE:
  - o_in_ready=0.
  - On i_start with i_len in 1..MAX_LEN: latch len, wr_ptr=0, go to FILL.
  - On i_start with i_len=0 or i_len>MAX_LEN: pulse o_err for one cycle and stay in IDLE.
- FILL:
  - o_in_ready=1.
  - Each transfer writes sign-extended a*b to buffer[wr_ptr] and increments wr_ptr.
  - The transfer with wr_ptr==len-1 moves to BURST on the next edge; o_in_ready drops in that next cycle.
  - A stalled i_in_valid simply waits; no timeout.
- BURST:
  - Read address increments 0..len-1, one per cycle; buffer read latency is 1 cycle.
  - o_valid is high for exactly len consecutive cycles, in the same order as written.
  - o_last is high coincident with the final o_valid only.
  - If T is the cycle of the final input transfer, the first o_valid is at T+2.
- GUARD:
  - One cycle with o_valid=0 and o_last=0, which guarantees the downstream clear.
  - Then return to IDLE.
- i_start outside IDLE is ignored, with no error.
- len=1: a single cycle with o_valid=1 and o_last=1.
- Arithmetic:
  - Full-precision signed DATA_W x DATA_W multiply, sign-extended to 32 bits.
  - Extreme case: -2048 * -2048 = 4194304 is representable and must not be truncated.
- o_busy=1 in FILL, BURST and GUARD.
- No backpressure on the output side; the downstream always accepts.

Optional Feature:
- Macro: CORR_FRAME_CNT_EN.
- When defined:
  - Adds output port o_frame_cnt, 16 bits, reset to 0.
  - Increments on each cycle where o_last=1, wrapping 0xFFFF to 0x0000.
  - A frame aborted by reset does not count.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package corr_pkg holds:
  - FSM state encoding (IDLE, FILL, BURST, GUARD)
  - DATA_W, MAX_LEN and ADDR_W defaults
  - output width constant 32
- Sub-module corr_prod_ram:
  - simple dual-port, one write port and one read port
  - depth MAX_LEN, width 32
  - registered read with 1-cycle latency
  - no reset on contents
- The multiply, FSM and counters live in corr_frame_gen.

Test Plan:
- i_start with i_len=4, pairs (1,2),(3,-4),(-5,6),(7,8) sent back-to-back -> o_data 2, -12 (0xFFFFFFF4), -30, 56 on 4 consecutive cycles; o_last on 56; first o_valid 2 cycles after the last transfer; one idle cycle; o_busy falls.
- i_len=1 with pair (-2048,-2048) -> single cycle o_valid=1, o_last=1, o_data=4194304.
- i_len=0, then i_len=65 -> o_err pulses once each; o_busy stays 0; no o_valid.
- i_len=64 with i_in_valid toggling every other cycle -> all 64 products emitted contiguously with no valid gap; i_start pulsed during BURST is ignored.
- Reset asserted mid-BURST of an 8-frame -> outputs 0 immediately; after release IDLE with o_valid=0; a new frame with i_len=2 then works correctly.
- CORR_FRAME_CNT_EN defined: 3 frames run -> o_frame_cnt reads 1, 2, 3 after each o_last; preload via 65535 frames (or forced state) -> wraps to 0.
